step_responder: RTL

- Responder side of the start/done step handshake driven by the S-Machine sequencer.
- Accepts a one-cycle start pulse with the sequencer's 8-bit step count.
- Performs one memory read at that step address through a req/ack bus, with a timeout.
- Returns the read data and a one-cycle done pulse that advances the sequencer.

---
 rtl/step_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/step_responder.sv
// ---------------------------------------------------------------------------
// step_responder
//
// Responder side of the sequencer start/done step handshake. When a
// one-cycle start pulse is accepted, the block captures the step index and
// performs one memory read at that address over a req/ack bus. It then
// returns the read data together with a one-cycle done pulse. A read that
// gets no acknowledge within TIMEOUT request cycles is aborted. That done
// pulse is qualified by error=1.
//
// Parameters:
//   DATA_W   width of mem_rdata and result
//   TIMEOUT  maximum REQ cycles without mem_ack before abort (2..255)
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   step request pulse from the sequencer
//   count      in   8-bit step index, captured when start is accepted
//   mem_ack    in   memory acknowledge, mem_rdata valid in the same cycle
//   mem_rdata  in   read data from memory
//   mem_req    out  memory request, high until ack or timeout
//   mem_addr   out  captured step index, stable while mem_req is high
//   result     out  last successfully read data
//   done       out  one-cycle completion pulse
//   error      out  done qualifier: transfer timed out (held to next start)
//   busy       out  high while in the REQ state
//   overrun    out  sticky: start seen while busy (cleared on next start)
// ---------------------------------------------------------------------------
module step_responder #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        count,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic [7:0]        mem_addr,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              error,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Value of the wait counter on the last REQ edge before abort.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              state_r,    state_s;
    logic [7:0]          wait_cnt_r, wait_cnt_s;
    logic [7:0]          mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   result_r,   result_s;
    logic                mem_req_r,  mem_req_s;
    logic                done_r,     done_s;
    logic                error_r,    error_s;
    logic                busy_r,     busy_s;
    logic                overrun_r,  overrun_s;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output logic. Every output is computed here and
    // registered below, so nothing combinational reaches a port.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        mem_addr_s = mem_addr_r;
        result_s   = result_r;
        mem_req_s  = mem_req_r;
        done_s     = 1'b0;
        error_s    = error_r;
        busy_s     = busy_r;
        overrun_s  = overrun_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_REQ;
                    mem_addr_s = count;
                    wait_cnt_s = 8'd0;
                    error_s    = 1'b0;
                    overrun_s  = 1'b0;
                    mem_req_s  = 1'b1;
                    busy_s     = 1'b1;
                end else begin
                    state_s    = ST_IDLE;
                    mem_req_s  = 1'b0;
                    busy_s     = 1'b0;
                end
            end

            ST_REQ: begin
                // A start while busy never restarts the transfer; it is only
                // recorded so the sequencer can detect the lost step.
                if (start) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end

                // Ack is tested first so it wins over a same-edge timeout.
                if (mem_ack) begin
                    state_s   = ST_DONE;
                    result_s  = mem_rdata;
                    mem_req_s = 1'b0;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                    error_s   = 1'b0;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s   = ST_DONE;
                    mem_req_s = 1'b0;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                    error_s   = 1'b1;
                end else begin
                    state_s    = ST_REQ;
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end

            ST_DONE: begin
                // A start in the done cycle is accepted directly, giving
                // back-to-back steps without an idle cycle.
                if (start) begin
                    state_s    = ST_REQ;
                    mem_addr_s = count;
                    wait_cnt_s = 8'd0;
                    error_s    = 1'b0;
                    overrun_s  = 1'b0;
                    mem_req_s  = 1'b1;
                    busy_s     = 1'b1;
                end else begin
                    state_s    = ST_IDLE;
                    mem_req_s  = 1'b0;
                    busy_s     = 1'b0;
                end
            end

            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
                busy_s    = 1'b0;
                done_s    = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= 8'd0;
            mem_addr_r <= 8'd0;
            result_r   <= {DATA_W{1'b0}};
            mem_req_r  <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            wait_cnt_r <= wait_cnt_s;
            mem_addr_r <= mem_addr_s;
            result_r   <= result_s;
            mem_req_r  <= mem_req_s;
            done_r     <= done_s;
            error_r    <= error_s;
            busy_r     <= busy_s;
            overrun_r  <= overrun_s;
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign result   = result_r;
    assign done     = done_r;
    assign error    = error_r;
    assign busy     = busy_r;
    assign overrun  = overrun_r;

endmodule
